octal_display_scanner: RTL and testbench

- Upstream feeder for the 3-bit seven-segment decoder in the 8x8 multiplier display path.
- Accepts the 16-bit multiplier product over a valid/ready handshake and splits it into six octal digits (max 177777).
- Time-multiplexes the digits onto one shared 3-bit decoder input with a one-hot digit enable and leading-zero blanking.
- Swaps in a new product only at frame boundaries, so the display never tears.

---
 rtl/octal_display_scanner.sv | 100 ++++++++++
 tb/tb_octal_display_scanner.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/octal_display_scanner.sv
// octal_display_scanner: shows a 16-bit product as six time-multiplexed octal digits with
// leading-zero blanking; new products are swapped in only at frame boundaries.
module octal_display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] product_in,
  input  logic        product_valid,
  output logic        product_ready,
  input  logic        clear,
  output logic [2:0]  digit_bin,
  output logic [5:0]  digit_en,
  output logic        frame_done
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;
  logic [15:0] disp_q, disp_d, pend_q, pend_d;
  logic pend_v_q, pend_v_d;
  logic [2:0] idx_q, idx_d, msd;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [5:0] digit_en_q, digit_en_d;
  logic [2:0] digit_bin_q, digit_bin_d;
  logic frame_done_q, frame_done_d;
  logic accept, tick, wrap;
  logic [23:0] ext;
  logic [2:0] dig [8];
  assign product_ready = !pend_v_q;
  assign accept = product_valid && product_ready && !clear;
  assign tick = state_q == SCAN && pre_q == DIV_W'(REFRESH_DIV - 1);
  assign wrap = tick && idx_q == 3'd5;
  assign digit_en = digit_en_q;
  assign digit_bin = digit_bin_q;
  assign frame_done = frame_done_q;
  always_comb begin
    state_d = state_q;
    disp_d = disp_q;
    pend_d = pend_q;
    pend_v_d = pend_v_q;
    idx_d = idx_q;
    pre_d = pre_q;
    if (clear) begin
      state_d = IDLE;
      disp_d = '0;
      pend_v_d = 1'b0;
      idx_d = '0;
      pre_d = '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        state_d = SCAN;
        disp_d = product_in;
        idx_d = '0;
        pre_d = '0;
      end
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) idx_d = wrap ? 3'd0 : idx_q + 3'd1;
      if (wrap && pend_v_q) begin
        disp_d = pend_q;
        pend_v_d = 1'b0;
      end
      // accept needs !pend_v, so it never collides with the swap above
      if (accept) begin
        pend_d = product_in;
        pend_v_d = 1'b1;
      end
    end
    frame_done_d = wrap && !clear;
    ext = {8'b0, disp_d};
    for (int k = 0; k < 8; k++) dig[k] = ext[3*k +: 3];
    msd = '0;
    for (int k = 1; k < 6; k++) if (dig[k] != 3'd0) msd = 3'(k);
    digit_en_d = (state_d == SCAN && idx_d <= msd) ? 6'(1) << idx_d : '0;
    digit_bin_d = digit_en_d != '0 ? dig[idx_d] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      disp_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      idx_q <= '0;
      pre_q <= '0;
      digit_en_q <= '0;
      digit_bin_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      idx_q <= idx_d;
      pre_q <= pre_d;
      digit_en_q <= digit_en_d;
      digit_bin_q <= digit_bin_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_octal_display_scanner.sv
// tb_octal_display_scanner: directed plus random stimulus against a frame-time display model.
module tb_octal_display_scanner;
  localparam int RD = 4;
  localparam int FRAME = 6 * RD;
  logic clk = 1'b0, rst = 1'b1, product_valid = 1'b0, clear = 1'b0;
  logic [15:0] product_in = '0;
  logic product_ready, frame_done;
  logic [2:0] digit_bin;
  logic [5:0] digit_en;
  int vectors = 0, miscompares = 0;
  bit active = 1'b0, fd = 1'b0;
  int t = 0;
  logic [15:0] shown = '0;
  logic [15:0] pq [$];

  octal_display_scanner #(.REFRESH_DIV(RD), .DIV_W(4)) dut (
    .clk(clk), .rst(rst), .product_in(product_in), .product_valid(product_valid),
    .product_ready(product_ready), .clear(clear), .digit_bin(digit_bin),
    .digit_en(digit_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic int ndig(input logic [15:0] v);
    int n = 1;
    int x = int'(v) / 8;
    while (x > 0) begin
      n++;
      x /= 8;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int k = t / RD;
    logic [5:0] en = '0;
    logic [2:0] bin = '0;
    if (active && k < ndig(shown)) begin
      en = 6'(1) << k;
      bin = 3'((int'(shown) / (8 ** k)) % 8);
    end
    chk("digit_en", 16'(digit_en), 16'(en));
    chk("digit_bin", 16'(digit_bin), 16'(bin));
    chk("frame_done", 16'(frame_done), 16'(fd));
    chk("product_ready", 16'(product_ready), 16'(pq.size() == 0));
  endtask

  task automatic model_reset();
    active = 1'b0;
    fd = 1'b0;
    t = 0;
    shown = '0;
    pq.delete();
  endtask

  task automatic model_step(input bit v, input logic [15:0] d, input bit c);
    bit acc = v && pq.size() == 0;
    fd = 1'b0;
    if (c) model_reset();
    else if (!active) begin
      if (v) begin
        active = 1'b1;
        shown = d;
        t = 0;
      end
    end else begin
      fd = (t == FRAME - 1);
      t = (t + 1) % FRAME;
      if (fd && pq.size() > 0) shown = pq.pop_front();
      if (acc) pq.push_back(d);
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] d, input bit c);
    product_valid = v;
    product_in = d;
    clear = c;
    @(posedge clk);
    model_step(v, d, c);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    #1 check_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    cyc(1'b1, 16'hFFFF, 1'b0);
    idle(2 * FRAME + 3);
    cyc(1'b1, 16'h1234, 1'b1);
    idle(3);
    cyc(1'b1, 16'd8, 1'b0);
    idle(FRAME + 2);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b1, 16'h0, 1'b0);
    idle(FRAME + 2);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b1, 16'h0041, 1'b0);
    idle(5);
    cyc(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) cyc(1'b1, 16'h0007, 1'b0);
    idle(2 * FRAME);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b1, 16'h0041, 1'b0);
    begin
      int n = 0;
      while (t != FRAME - 1 && n < 2 * FRAME) begin
        cyc(1'b0, 16'h0, 1'b0);
        n++;
      end
      if (t != FRAME - 1) begin
        vectors++;
        miscompares++;
        $error("FAIL wrap_wait observed t=%0d expected t=%0d", t, FRAME - 1);
      end
    end
    cyc(1'b1, 16'h0003, 1'b0);
    idle(2 * FRAME + 2);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) == 0, 16'($urandom) >> $urandom_range(0, 15), $urandom_range(0, 49) == 0);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b1, 16'h0041, 1'b0);
    idle(7);
    cyc(1'b1, 16'h5555, 1'b0);
    idle(2);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    #2 rst = 1'b0;
    idle(3);
    cyc(1'b1, 16'o177, 1'b0);
    idle(FRAME + 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
